// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// fir_tap_sequencer: circular sample delay line plus coefficient table, streaming first/last-tagged
// tap pairs to a serial MAC. Define FIR_TAP_SEQUENCER_CLEAR_EN to zero-fill the delay line after reset.
module fir_tap_sequencer #(
  parameter int NTAPS = 64,
  parameter int AW    = 6,
  parameter int DEC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [17:0] din,
  input  logic               div,
  input  logic               cwe,
  input  logic [AW-1:0]      caddr,
  input  logic signed [24:0] cdata,
  output logic signed [17:0] dout,
  output logic signed [24:0] cout,
  output logic               first,
  output logic               last,
  output logic               ov,
  output logic               busy,
  output logic               ovr
);

  localparam int DEPTH = 2 ** AW;
  localparam int DW    = (DEC > 1) ? $clog2(DEC) : 1;
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  localparam logic [DW-1:0] LAST_CNT = DW'(DEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

`ifdef FIR_TAP_SEQUENCER_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t             state;
  logic [AW-1:0]      wp;
  logic [AW-1:0]      tap;
  logic [AW-1:0]      ta;
  logic [AW-1:0]      pend_ta;
  logic [DW-1:0]      dcnt;
  logic               pend;

  logic signed [17:0] smem [DEPTH];
  logic signed [24:0] cmem [DEPTH];
  logic signed [17:0] srd;
  logic signed [24:0] crd;
  logic               rd_v;
  logic               rd_first;
  logic               rd_last;

  logic               accept;
  logic               trig;
  logic               swe;
  logic signed [17:0] swd;
  logic [AW-1:0]      saddr;

  assign accept = div && (state != S_CLEAR);
  assign trig   = accept && (dcnt == LAST_CNT);
  assign swe    = accept || (state == S_CLEAR);
  assign swd    = (state == S_CLEAR) ? '0 : din;
  assign saddr  = ta - tap;
  assign busy   = (state != S_IDLE) || pend;

  // Both tables are plain synchronous RAMs: a read on the write edge sees the old word.
  always_ff @(posedge clk) begin
    if (swe) smem[wp] <= swd;
    if (cwe) cmem[caddr] <= cdata;
    srd <= smem[saddr];
    crd <= cmem[tap];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      wp       <= '0;
      tap      <= '0;
      ta       <= '0;
      pend_ta  <= '0;
      dcnt     <= '0;
      pend     <= 1'b0;
      ovr      <= 1'b0;
      rd_v     <= 1'b0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
      ov       <= 1'b0;
      first    <= 1'b0;
      last     <= 1'b0;
      dout     <= '0;
      cout     <= '0;
    end else begin
      rd_v     <= (state == S_RUN);
      rd_first <= (state == S_RUN) && (tap == '0);
      rd_last  <= (state == S_RUN) && (tap == LAST_TAP);
      ov       <= rd_v;
      first    <= rd_v && rd_first;
      last     <= rd_v && rd_last;
      if (rd_v) begin
        dout <= srd;
        cout <= crd;
      end

      if (accept) begin
        wp   <= wp + 1'b1;
        dcnt <= (dcnt == LAST_CNT) ? '0 : dcnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (trig) begin
            state <= S_RUN;
            tap   <= '0;
            ta    <= wp;
          end
        end
        S_RUN: begin
          if (tap == LAST_TAP) begin
            tap <= '0;
            // The pending slot frees as its pass starts, so a trigger on this edge takes it.
            if (pend) begin
              ta   <= pend_ta;
              pend <= trig;
              if (trig) pend_ta <= wp;
            end else if (trig) begin
              ta <= wp;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            tap <= tap + 1'b1;
            if (trig) begin
              if (pend) begin
                ovr <= 1'b1;
              end else begin
                pend    <= 1'b1;
                pend_ta <= wp;
              end
            end
          end
        end
        S_CLEAR: begin
          wp <= wp + 1'b1;
          if (wp == '1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
